// File: rtl/my_or_accum_16.sv
`default_nettype none
// ============================================================================
// Module   : my_or_accum_16
// Purpose  : OR-reduces each frame of COUNT 16-bit words, received over a
//            valid/ready handshake, into one registered result word that is
//            presented on a valid/ready output port. The frame then clears
//            and the next frame starts.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            clear      - synchronous abort of the current frame
//            in_valid   - in_data valid
//            in_ready   - block can accept in_data this cycle
//            in_data    - word to OR into the accumulator (16 bits)
//            out_valid  - out_data/out_beats hold a finished frame
//            out_ready  - consumer accepts the result
//            out_data   - OR of all words in the frame (16 bits)
//            out_beats  - number of words merged into out_data (8 bits)
//            busy       - high while a frame is accumulating or done
// Config   : MY_OR_ACCUM_EARLY_DONE_EN - when defined, a frame also ends as
//            soon as the accumulated word reaches 16'hFFFF.
// Revision : 1.0 - initial release
// ============================================================================

// Per-beat merge primitive.
module my_or_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

module my_or_accum_16 #(
  parameter int COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [7:0]  out_beats,
  output logic        busy
);

  localparam int CNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] C_COUNT = CNT_W'(COUNT);

  logic [1:0]       state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic [15:0]      w_merged;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_last;

  my_or_16 u_or (
    .a_i (acc_q),
    .b_i (in_data),
    .y_o (w_merged)
  );

  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = cnt_q + 8'd1;

  // The beat being accepted closes the frame.
`ifdef MY_OR_ACCUM_EARLY_DONE_EN
  assign w_last = (w_cnt_inc == C_COUNT) | (w_merged == 16'hFFFF);
`else
  assign w_last = (w_cnt_inc == C_COUNT);
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 16'h0000;
      cnt_q       <= '0;
      out_data_q  <= 16'h0000;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  // Next-state logic. clear outranks both a beat and an output handshake.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            state_d = w_last ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values. The result registers capture the merged word on
  // the closing beat so out_valid and out_data appear in the same cycle.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    if (clear) begin
      acc_d       = 16'h0000;
      cnt_d       = '0;
      out_data_d  = 16'h0000;
      out_beats_d = '0;
    end else if ((state_q == S_DONE) && out_ready) begin
      acc_d = 16'h0000;
      cnt_d = '0;
    end else if (w_accept) begin
      acc_d = w_merged;
      cnt_d = w_cnt_inc;
      if (w_last) begin
        out_data_d  = w_merged;
        out_beats_d = w_cnt_inc;
      end
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q != S_DONE) & ~clear;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out_data  = out_data_q;
    out_beats = out_beats_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_my_or_accum_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_or_accum_16
// Purpose  : Self-checking bench for my_or_accum_16 (COUNT=4). Directed
//            sequences plus randomized traffic are compared every cycle
//            against a frame-level reference model built from a word queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_or_accum_16;

  localparam int COUNT = 4;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_beats;
  logic        busy;

  my_or_accum_16 #(.COUNT(COUNT)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words of the open frame, plus the pending result.
  logic [15:0] m_frame[$];
  logic        m_have;
  logic [15:0] m_data;
  logic [7:0]  m_beats;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_or();
    logic [15:0] r = 16'h0000;
    foreach (m_frame[i]) r = r | m_frame[i];
    return r;
  endfunction

  function automatic bit frame_closes();
    if (m_frame.size() == COUNT) return 1'b1;
`ifdef MY_OR_ACCUM_EARLY_DONE_EN
    if (frame_or() == 16'hFFFF) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_frame.delete();
    m_have  = 1'b0;
    m_data  = 16'h0000;
    m_beats = 8'd0;
  endtask

  task automatic check_outputs(input bit clr);
    check("in_ready",  in_ready,  !m_have && !clr);
    check("out_valid", out_valid, m_have);
    check("out_data",  out_data,  m_data);
    check("out_beats", out_beats, m_beats);
    check("busy",      busy,      m_have || (m_frame.size() != 0));
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model to reflect the coming rising edge.
  task automatic cycle(input bit v, input logic [15:0] d, input bit rdy, input bit clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clear     = clr;
    #1;
    check_outputs(clr);
    if (clr) begin
      model_reset();
    end else if (m_have) begin
      if (rdy) m_have = 1'b0;
    end else if (v) begin
      m_frame.push_back(d);
      if (frame_closes()) begin
        m_have  = 1'b1;
        m_data  = frame_or();
        m_beats = 8'(m_frame.size());
        m_frame.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  function automatic logic [15:0] rand_word();
    if ($urandom_range(3) == 0) return 16'($urandom);
    return 16'(1) << $urandom_range(15);
  endfunction

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    model_reset();

    // Reset state.
    #12;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back frame, consumer always ready.
    cycle(1, 16'h0001, 1, 0);
    cycle(1, 16'h0010, 1, 0);
    cycle(1, 16'h0100, 1, 0);
    cycle(1, 16'h1000, 1, 0);
    idle(2);

    // Backpressure: beats offered while the result waits are not consumed.
    cycle(1, 16'h0001, 0, 0);
    cycle(1, 16'h0010, 0, 0);
    cycle(1, 16'h0100, 0, 0);
    cycle(1, 16'h1000, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 16'h0002, 0, 0);
    cycle(1, 16'h0002, 1, 0);
    cycle(1, 16'h0002, 1, 0);
    cycle(1, 16'h0002, 1, 0);
    cycle(1, 16'h0002, 1, 0);
    cycle(1, 16'h0002, 1, 0);
    idle(2);

    // Gaps between beats.
    cycle(1, 16'hE000, 1, 0); cycle(0, 16'hFFFF, 1, 0);
    cycle(1, 16'hA000, 1, 0); cycle(0, 16'hFFFF, 1, 0);
    cycle(1, 16'h000C, 1, 0); cycle(0, 16'hFFFF, 1, 0);
    cycle(1, 16'h0000, 1, 0);
    idle(2);

    // clear together with a valid beat, then a fresh frame.
    cycle(1, 16'h0700, 1, 0);
    cycle(1, 16'h0080, 1, 0);
    cycle(1, 16'h4000, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0003, 1, 0);
    idle(2);

    // clear while a result is waiting.
    for (int i = 0; i < 4; i++) cycle(1, 16'h0050, 0, 0);
    cycle(0, 16'h0000, 1, 1);
    idle(1);

    // Asynchronous reset between edges, mid-frame.
    cycle(1, 16'h8000, 1, 0);
    cycle(1, 16'h0F00, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 16'h00FF, 1, 0);
    idle(2);

    // Complementary halves: early finish only when the option is built in.
    cycle(1, 16'hFF00, 1, 0);
    cycle(1, 16'h00FF, 1, 0);
    cycle(1, 16'h0001, 1, 0);
    cycle(1, 16'h0002, 1, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(3) != 0), rand_word(), ($urandom_range(2) != 0),
            ($urandom_range(60) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
